reg_wb_ctrl: RTL
================

Name: reg_wb_ctrl

Overview:
Writeback controller that drives the write port of the 32x32 register file.
- Collects destination writes from the ALU path and the load (memory) path through valid/ready handshakes, and buffers them in a small in-order queue.
- Issues at most one write per cycle to the register file, and only in cycles when decode is not requesting a read; the register file cannot read and write in the same cycle.
- Exports a pending-destination vector so decode can stall on registers with a queued write.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
DATA_W, 32, register data width
ADDR_W, 5, register address width

Ports:
WB_clk  in  1  clock, rising edge
WB_rst  in  1  asynchronous reset, active-high
WB_mem_valid  in  1  load-path write request
WB_mem_addr  in  ADDR_W  load-path destination register
WB_mem_data  in  DATA_W  load-path write data
WB_mem_ready  out  1  load-path request accepted this edge
WB_alu_valid  in  1  ALU-path write request
WB_alu_addr  in  ADDR_W  ALU-path destination register
WB_alu_data  in  DATA_W  ALU-path write data
WB_alu_ready  out  1  ALU-path request accepted this edge
WB_rd_req  in  1  decode needs a register-file read at the next edge
WB_reg_write  out  1  write enable to register file
WB_reg_addr  out  ADDR_W  write address to register file
WB_reg_data  out  DATA_W  write data to register file
WB_pending  out  32  bit i = queued write targets register i
WB_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- One clock, WB_clk. Reset is asynchronous and active-high on WB_rst.
- Reset:
  - Queue empty; WB_count=0.
  - WB_reg_write, WB_reg_addr and WB_reg_data all 0.
  - WB_pending=0.
  - Readies reflect an empty queue once reset deasserts.
- Handshake:
  - A transfer occurs at a rising edge when valid && ready.
  - A source holds valid, addr and data stable until accepted. There is no drop and no overflow.
- Ready rules: combinational from the registered count only. A same-edge pop is not credited.
  - free = DEPTH - WB_count.
  - WB_mem_ready = (free >= 1).
  - WB_alu_ready = (free >= 2) || (free == 1 && !WB_mem_valid).
- Ordering:
  - When both sources are accepted at the same edge, the mem entry is enqueued ahead of the alu entry (the load is older).
  - The queue is strictly FIFO.
- Register 0:
  - A request with addr == 0 is handshaken (ready as above) but not enqueued.
  - It never produces WB_reg_write and never sets WB_pending.
- Issue (registered outputs):
  - At each edge, if the queue is non-empty (pre-edge contents) and WB_rd_req == 0: pop the head, drive WB_reg_addr/WB_reg_data with it, and set WB_reg_write=1 for exactly that cycle.
  - Otherwise WB_reg_write=0; WB_reg_addr and WB_reg_data hold their last values.
  - Consequence: WB_reg_write is 0 during the cycle after any edge where WB_rd_req=1, so the register file captures its read at the following edge.
- Latency: request accepted at edge N, queue empty, WB_rd_req low at N+1 -> WB_reg_write high in the cycle after edge N+1.
- WB_count: next = count + enq_count - pop, where enq_count is 0..2. Pop and enqueue at the same edge are legal at any occupancy, including full with pop.
- WB_pending:
  - Combinational OR of the one-hot decodes of every valid queue entry's address.
  - The entry currently on the WB_reg_* outputs is excluded (already popped).
- Pointers: wrap modulo DEPTH.
- Reset mid-operation: queue flushed, queued writes lost, WB_reg_write forced 0 immediately (asynchronous).

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - If the queue is empty (pre-edge), WB_rd_req == 0, and a request with addr != 0 is accepted at edge N, it skips the queue and appears on WB_reg_* with WB_reg_write=1 in the cycle after edge N.
  - If both sources are accepted together, mem bypasses and alu is enqueued.
  - WB_pending is not set for a bypassed entry.
- Undefined: every accepted write goes through the queue; minimum latency is 2 edges, as in Behaviour.

Test Plan:
- Reset, then ALU write addr=5, data=0xDEADBEEF, WB_rd_req=0 -> WB_reg_write=1, WB_reg_addr=5, WB_reg_data=0xDEADBEEF one cycle after the dequeue edge (the cycle after acceptance with WB_BYPASS_EN); WB_pending[5] set while queued; WB_count returns to 0.
- Mem (addr=3, 0x11) and ALU (addr=4, 0x22) valid together, queue empty -> both accepted at one edge; issue order addr 3 then addr 4 on consecutive cycles.
- WB_rd_req=1 for 3 cycles with 2 entries queued -> WB_reg_write=0 for 3 cycles; then entries issue in order; WB_count holds 2 while blocked.
- DEPTH=4, WB_rd_req=1, 5 ALU requests (addr 1..5) -> 4 accepted, WB_alu_ready=0 at WB_count=4; fifth accepted at the edge after the first pop.
- Write with addr=0, data=0xFFFFFFFF -> ready=1, accepted; WB_count stays 0; no WB_reg_write pulse; WB_pending=0.
- WB_rd_req=1, 3 entries queued, assert WB_rst between edges -> WB_reg_write, WB_count and WB_pending go 0 immediately; after release no stale write issues.

Source files
------------

// File: rtl/reg_wb_ctrl_if.sv
// Writeback bus: ALU/load write requests in, register-file write port and status out.
interface reg_wb_ctrl_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              WB_mem_valid;
  logic [ADDR_W-1:0] WB_mem_addr;
  logic [DATA_W-1:0] WB_mem_data;
  logic              WB_mem_ready;
  logic              WB_alu_valid;
  logic [ADDR_W-1:0] WB_alu_addr;
  logic [DATA_W-1:0] WB_alu_data;
  logic              WB_alu_ready;
  logic              WB_rd_req;
  logic              WB_reg_write;
  logic [ADDR_W-1:0] WB_reg_addr;
  logic [DATA_W-1:0] WB_reg_data;
  logic [31:0]       WB_pending;
  logic [CNT_W-1:0]  WB_count;

  modport master (
    output WB_mem_valid, WB_mem_addr, WB_mem_data,
    output WB_alu_valid, WB_alu_addr, WB_alu_data,
    output WB_rd_req,
    input  WB_mem_ready, WB_alu_ready,
    input  WB_reg_write, WB_reg_addr, WB_reg_data,
    input  WB_pending, WB_count
  );

  modport slave (
    input  WB_mem_valid, WB_mem_addr, WB_mem_data,
    input  WB_alu_valid, WB_alu_addr, WB_alu_data,
    input  WB_rd_req,
    output WB_mem_ready, WB_alu_ready,
    output WB_reg_write, WB_reg_addr, WB_reg_data,
    output WB_pending, WB_count
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: in-order queue of ALU/load writes, issued on free read slots.
// Optional queue bypass for an empty queue is enabled by defining WB_BYPASS_EN.
module reg_wb_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic         WB_clk,
  input  logic         WB_rst,
  reg_wb_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_data;

  logic [CNT_W-1:0]  w_free;
  logic              w_mem_ready;
  logic              w_alu_ready;
  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_mem_enq;
  logic              w_alu_enq;
  logic              w_byp_mem;
  logic              w_byp_alu;
  logic              w_pop;
  logic [1:0]        w_enq_n;
  logic [PTR_W-1:0]  w_alu_slot;
  logic [31:0]       w_pending;

  // Readies look only at the registered count; a same-edge pop earns no credit.
  assign w_free      = CNT_W'(DEPTH) - r_count;
  assign w_mem_ready = (w_free >= CNT_W'(1));
  assign w_alu_ready = (w_free >= CNT_W'(2)) ||
                       ((w_free == CNT_W'(1)) && !bus.WB_mem_valid);

  assign w_mem_acc = bus.WB_mem_valid && w_mem_ready;
  assign w_alu_acc = bus.WB_alu_valid && w_alu_ready;
  assign w_pop     = (r_count != '0) && !bus.WB_rd_req;

`ifdef WB_BYPASS_EN
  logic w_byp_ok;
  assign w_byp_ok  = (r_count == '0) && !bus.WB_rd_req;
  assign w_byp_mem = w_byp_ok && w_mem_acc && (bus.WB_mem_addr != '0);
  assign w_byp_alu = w_byp_ok && !w_byp_mem && w_alu_acc && (bus.WB_alu_addr != '0);
`else
  assign w_byp_mem = 1'b0;
  assign w_byp_alu = 1'b0;
`endif

  // Writes to r0 complete the handshake but are discarded.
  assign w_mem_enq  = w_mem_acc && (bus.WB_mem_addr != '0) && !w_byp_mem;
  assign w_alu_enq  = w_alu_acc && (bus.WB_alu_addr != '0) && !w_byp_alu;
  assign w_enq_n    = {1'b0, w_mem_enq} + {1'b0, w_alu_enq};
  assign w_alu_slot = w_mem_enq ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;

  // Queue storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge WB_clk) begin
    if (w_mem_enq) begin
      r_q_addr[r_wr_ptr] <= bus.WB_mem_addr;
      r_q_data[r_wr_ptr] <= bus.WB_mem_data;
    end
    if (w_alu_enq) begin
      r_q_addr[w_alu_slot] <= bus.WB_alu_addr;
      r_q_data[w_alu_slot] <= bus.WB_alu_data;
    end
  end

  always_ff @(posedge WB_clk or posedge WB_rst) begin
    if (WB_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_reg_write <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_data  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_enq_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_pop);
      // Pop and bypass are exclusive: bypass requires an empty queue.
      if (w_pop) begin
        r_reg_write <= 1'b1;
        r_reg_addr  <= r_q_addr[r_rd_ptr];
        r_reg_data  <= r_q_data[r_rd_ptr];
      end else if (w_byp_mem) begin
        r_reg_write <= 1'b1;
        r_reg_addr  <= bus.WB_mem_addr;
        r_reg_data  <= bus.WB_mem_data;
      end else if (w_byp_alu) begin
        r_reg_write <= 1'b1;
        r_reg_addr  <= bus.WB_alu_addr;
        r_reg_data  <= bus.WB_alu_data;
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count) begin
        w_pending[r_q_addr[i]] = 1'b1;
      end
    end
  end

  assign bus.WB_mem_ready = w_mem_ready;
  assign bus.WB_alu_ready = w_alu_ready;
  assign bus.WB_reg_write = r_reg_write;
  assign bus.WB_reg_addr  = r_reg_addr;
  assign bus.WB_reg_data  = r_reg_data;
  assign bus.WB_pending   = w_pending;
  assign bus.WB_count     = r_count;
endmodule
